// File: rtl/plic_claim_complete_master.sv
// Hart-side PLIC claim/complete engine: on irq reads the target claim register over AXI4,
// hands the source ID to a consumer, then writes it back as the completion.
module plic_claim_complete_master #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH = 2,
   parameter int unsigned SRCW = 5,
   parameter logic [AXI_ADDR_WIDTH-1:0] PLIC_BASE = 32'h0400_0000,
   parameter int unsigned TARGET_ID = 0,
   parameter int unsigned HOLDOFF = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        irq_i,
   output logic                        claim_valid_o,
   output logic [SRCW-1:0]             claim_id_o,
   input  logic                        claim_ready_i,
   input  logic                        done_valid_i,
   output logic                        done_ready_o,
   output logic                        busy_o,
   output logic                        err_o,
   output logic [15:0]                 spurious_cnt_o,
   output logic                        m_axi_arvalid,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]                  m_axi_arlen,
   output logic [2:0]                  m_axi_arsize,
   output logic [1:0]                  m_axi_arburst,
   output logic                        m_axi_arlock,
   output logic [3:0]                  m_axi_arcache,
   output logic [2:0]                  m_axi_arprot,
   output logic [3:0]                  m_axi_arqos,
   output logic [3:0]                  m_axi_arregion,
   input  logic                        m_axi_arready,
   input  logic                        m_axi_rvalid,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        m_axi_rlast,
   output logic                        m_axi_rready,
   output logic                        m_axi_awvalid,
   output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                  m_axi_awlen,
   output logic [2:0]                  m_axi_awsize,
   output logic [1:0]                  m_axi_awburst,
   output logic                        m_axi_awlock,
   output logic [3:0]                  m_axi_awcache,
   output logic [2:0]                  m_axi_awprot,
   output logic [3:0]                  m_axi_awqos,
   output logic [3:0]                  m_axi_awregion,
   input  logic                        m_axi_awready,
   output logic                        m_axi_wvalid,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                        m_axi_wlast,
   input  logic                        m_axi_wready,
   input  logic                        m_axi_bvalid,
   input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
   input  logic [1:0]                  m_axi_bresp,
   output logic                        m_axi_bready
);

   localparam int unsigned HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] CLAIM_ADDR =
      PLIC_BASE + AXI_ADDR_WIDTH'(32'h0020_0004 + TARGET_ID * 32'h1000);

   if (AXI_DATA_WIDTH != 32) begin : g_bad_data_width
      $error("plic_claim_complete_master: AXI_DATA_WIDTH must be 32");
   end
   if (HOLDOFF < 1) begin : g_bad_holdoff
      $error("plic_claim_complete_master: HOLDOFF must be >= 1");
   end

   typedef enum logic [2:0] {
      StIdle, StAr, StR, StDeliver, StWaitDone, StWr, StB
   } state_e;

   state_e          state_q, state_d;
   logic [HW-1:0]   holdoff_q, holdoff_d;
   logic [SRCW-1:0] claim_id_q, claim_id_d;
   logic            err_q, err_d;
   logic [15:0]     spur_q, spur_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic            aw_fire, w_fire;
   logic            unused_inputs;

   assign aw_fire = m_axi_awvalid && m_axi_awready;
   assign w_fire  = m_axi_wvalid && m_axi_wready;

   always_comb begin
      state_d    = state_q;
      holdoff_d  = holdoff_q;
      claim_id_d = claim_id_q;
      err_d      = err_q;
      spur_d     = spur_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      unique case (state_q)
         StIdle: begin
            if (holdoff_q != '0) begin
               holdoff_d = holdoff_q - HW'(1);
            end else if (irq_i) begin
               state_d = StAr;
            end
         end
         StAr: if (m_axi_arready) state_d = StR;
         StR: begin
            if (m_axi_rvalid) begin
               if (m_axi_rresp != 2'b00) begin
                  err_d     = 1'b1;
                  holdoff_d = HW'(HOLDOFF);
                  state_d   = StIdle;
               end else if (m_axi_rdata[SRCW-1:0] == '0) begin
                  if (spur_q != 16'hFFFF) spur_d = spur_q + 16'd1;
                  holdoff_d = HW'(HOLDOFF);
                  state_d   = StIdle;
               end else begin
                  claim_id_d = m_axi_rdata[SRCW-1:0];
                  state_d    = StDeliver;
               end
            end
         end
         StDeliver: if (claim_ready_i) state_d = StWaitDone;
         StWaitDone: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (done_valid_i) state_d = StWr;
         end
         StWr: begin
            // AW and W complete independently; each valid is dropped once its beat is taken
            if (aw_fire) aw_done_d = 1'b1;
            if (w_fire) w_done_d = 1'b1;
            if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = StB;
         end
         StB: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != 2'b00) err_d = 1'b1;
               holdoff_d = HW'(HOLDOFF);
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         holdoff_q  <= '0;
         claim_id_q <= '0;
         err_q      <= 1'b0;
         spur_q     <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         holdoff_q  <= holdoff_d;
         claim_id_q <= claim_id_d;
         err_q      <= err_d;
         spur_q     <= spur_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

   assign claim_valid_o  = (state_q == StDeliver);
   assign claim_id_o     = claim_id_q;
   assign done_ready_o   = (state_q == StWaitDone);
   assign busy_o         = (state_q != StIdle);
   assign err_o          = err_q;
   assign spurious_cnt_o = spur_q;

   assign m_axi_arvalid  = (state_q == StAr);
   assign m_axi_arid     = '0;
   assign m_axi_araddr   = CLAIM_ADDR;
   assign m_axi_arlen    = 8'd0;
   assign m_axi_arsize   = 3'b010;
   assign m_axi_arburst  = 2'b01;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_arcache  = 4'd0;
   assign m_axi_arprot   = 3'd0;
   assign m_axi_arqos    = 4'd0;
   assign m_axi_arregion = 4'd0;
   assign m_axi_rready   = (state_q == StR);

   assign m_axi_awvalid  = (state_q == StWr) && !aw_done_q;
   assign m_axi_awid     = '0;
   assign m_axi_awaddr   = CLAIM_ADDR;
   assign m_axi_awlen    = 8'd0;
   assign m_axi_awsize   = 3'b010;
   assign m_axi_awburst  = 2'b01;
   assign m_axi_awlock   = 1'b0;
   assign m_axi_awcache  = 4'd0;
   assign m_axi_awprot   = 3'd0;
   assign m_axi_awqos    = 4'd0;
   assign m_axi_awregion = 4'd0;
   assign m_axi_wvalid   = (state_q == StWr) && !w_done_q;
   assign m_axi_wdata    = AXI_DATA_WIDTH'(claim_id_q);
   assign m_axi_wstrb    = '1;
   assign m_axi_wlast    = 1'b1;
   assign m_axi_bready   = (state_q == StB);

   // IDs, rlast and the upper claim data bits carry no meaning for a single-beat claim
   assign unused_inputs = ^{m_axi_rid, m_axi_bid, m_axi_rlast, m_axi_rdata[AXI_DATA_WIDTH-1:SRCW]};

endmodule

// File: tb/tb_plic_claim_complete_master.sv
// Randomised bench for plic_claim_complete_master: the stimulus task pushes expected claims
// and completions into queues; a negedge monitor pops and checks them at every handshake.
module tb_plic_claim_complete_master;
   localparam int SRCW = 5;
   localparam int HOLDOFF = 2;
   localparam logic [31:0] EXP_ADDR = 32'h0420_0004;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic irq = 0, claim_ready = 0, done_valid = 0;
   logic claim_valid, done_ready, busy, err;
   logic [SRCW-1:0] claim_id;
   logic [15:0] spur;
   logic arvalid, arready = 0, arlock;
   logic [1:0] arid, arburst;
   logic [31:0] araddr;
   logic [7:0] arlen;
   logic [2:0] arsize, arprot;
   logic [3:0] arcache, arqos, arregion;
   logic rvalid = 0, rlast = 1, rready;
   logic [1:0] rid = 2'b01, rresp = 0;
   logic [31:0] rdata = 0;
   logic awvalid, awready = 0, awlock;
   logic [1:0] awid, awburst;
   logic [31:0] awaddr;
   logic [7:0] awlen;
   logic [2:0] awsize, awprot;
   logic [3:0] awcache, awqos, awregion;
   logic wvalid, wlast, wready = 0;
   logic [31:0] wdata;
   logic [3:0] wstrb;
   logic bvalid = 0, bready;
   logic [1:0] bid = 2'b10, bresp = 0;

   int n_checks = 0;
   int n_err = 0;
   logic [SRCW-1:0] exp_claim_q[$];
   logic [31:0] exp_aw_q[$];
   logic [SRCW-1:0] exp_w_q[$];
   logic m_err = 0;
   int m_spur = 0;
   int next_lat = 1;

   always #5 clk = ~clk;

   plic_claim_complete_master #(.HOLDOFF(HOLDOFF)) dut (
      .clk_i(clk), .rst_ni(rst_n), .irq_i(irq),
      .claim_valid_o(claim_valid), .claim_id_o(claim_id), .claim_ready_i(claim_ready),
      .done_valid_i(done_valid), .done_ready_o(done_ready), .busy_o(busy), .err_o(err),
      .spurious_cnt_o(spur),
      .m_axi_arvalid(arvalid), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
      .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
      .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
      .m_axi_arregion(arregion), .m_axi_arready(arready),
      .m_axi_rvalid(rvalid), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rlast(rlast), .m_axi_rready(rready),
      .m_axi_awvalid(awvalid), .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
      .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
      .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
      .m_axi_awregion(awregion), .m_axi_awready(awready),
      .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_wready(wready),
      .m_axi_bvalid(bvalid), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bready(bready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int w);
      case (w)
         0: return arvalid;
         1: return rready;
         2: return claim_valid;
         3: return done_ready;
         4: return awvalid;
         5: return wvalid;
         6: return bready;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_sig(input int w, input string name, output int n);
      n = 0;
      while (!sig(w) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) chk(name, 64'd0, 64'd1);
   endtask

   // Negedge monitor: handshake checks against the queues, plus valid/payload stability.
   logic p_arv, p_arr, p_clv, p_clr, p_awv, p_awr, p_wv, p_wr;
   logic [31:0] p_araddr, p_awaddr, p_wdata;
   logic [SRCW-1:0] p_clid;
   always @(negedge clk) begin
      if (!rst_n) begin
         {p_arv, p_arr, p_clv, p_clr, p_awv, p_awr, p_wv, p_wr} = '0;
      end else begin
         if (arvalid && arready) begin
            chk("ar_addr", araddr, EXP_ADDR);
            chk("ar_fields", {arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos,
                              arregion}, {2'd0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
         end
         if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
         if (claim_valid) begin
            chk("claim_expected", exp_claim_q.size() != 0, 1'b1);
            if (claim_ready && exp_claim_q.size() != 0)
               chk("claim_id", claim_id, exp_claim_q.pop_front());
         end
         if (p_clv && !p_clr) chk("claim_hold", {claim_valid, claim_id}, {1'b1, p_clid});
         if (awvalid) begin
            chk("aw_expected", exp_aw_q.size() != 0, 1'b1);
            if (awready && exp_aw_q.size() != 0) begin
               chk("aw_addr", awaddr, exp_aw_q.pop_front());
               chk("aw_fields", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
                                 awregion}, {2'd0, 8'd0, 3'b010, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0});
            end
         end
         if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
         if (wvalid) begin
            chk("w_expected", exp_w_q.size() != 0, 1'b1);
            if (wready && exp_w_q.size() != 0) begin
               chk("w_data", wdata, {27'd0, exp_w_q.pop_front()});
               chk("w_strb_last", {wstrb, wlast}, 5'b1111_1);
            end
         end
         if (p_wv && !p_wr) chk("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
         {p_arv, p_arr, p_araddr} = {arvalid, arready, araddr};
         {p_clv, p_clr, p_clid} = {claim_valid, claim_ready, claim_id};
         {p_awv, p_awr, p_awaddr} = {awvalid, awready, awaddr};
         {p_wv, p_wr, p_wdata} = {wvalid, wready, wdata};
      end
   end

   task automatic run_txn(input logic [SRCW-1:0] id, input logic [1:0] rr, input logic [1:0] br,
                          input int cl_dly, input int aw_dly, input int w_dly, input bit rst_mid);
      int n;
      logic [31:0] rd;
      irq = 1;
      wait_sig(0, "ar_timeout", n);
      chk("ar_latency", n, next_lat);
      irq = 0;
      next_lat = HOLDOFF + 1;
      repeat ($urandom_range(0, 3)) step();
      arready = 1;
      step();
      arready = 0;
      repeat ($urandom_range(0, 3)) step();
      rd = $urandom();
      rd[SRCW-1:0] = id;
      rdata = rd;
      rresp = rr;
      if (rr == 2'b00 && id != 0) exp_claim_q.push_back(id);
      rvalid = 1;
      wait_sig(1, "r_timeout", n);
      step();
      rvalid = 0;
      if (rr != 2'b00) m_err = 1;
      else if (id == 0 && m_spur < 16'hFFFF) m_spur++;
      chk("err_after_r", err, m_err);
      chk("spur_cnt", spur, m_spur);
      if (rr != 2'b00 || id == 0) begin
         chk("idle_after_r", {busy, claim_valid}, 2'b00);
         return;
      end
      chk("claim_latency", claim_valid, 1'b1);
      repeat (cl_dly) step();
      claim_ready = 1;
      wait_sig(2, "claim_timeout", n);
      step();
      claim_ready = 0;
      chk("done_ready", {done_ready, arvalid, awvalid, wvalid}, 4'b1000);
      if (rst_mid) begin
         rst_n = 0;
         step();
         chk("reset_outputs", {claim_valid, claim_id, done_ready, busy, err, spur, arvalid, rready,
                               awvalid, wvalid, bready}, '0);
         rst_n = 1;
         m_err = 0;
         m_spur = 0;
         next_lat = 1;
         return;
      end
      repeat ($urandom_range(0, 3)) step();
      exp_aw_q.push_back(EXP_ADDR);
      exp_w_q.push_back(id);
      done_valid = 1;
      wait_sig(3, "done_timeout", n);
      step();
      done_valid = 0;
      chk("wr_latency", {awvalid, wvalid}, 2'b11);
      fork
         begin
            repeat (aw_dly) step();
            awready = 1;
            wait_sig(4, "aw_timeout", n);
            step();
            awready = 0;
         end
         begin
            int m;
            repeat (w_dly) step();
            wready = 1;
            wait_sig(5, "w_timeout", m);
            step();
            wready = 0;
         end
      join
      chk("aw_w_drained", {awvalid, wvalid, exp_aw_q.size() == 0, exp_w_q.size() == 0}, 4'b0011);
      repeat ($urandom_range(0, 3)) step();
      bresp = br;
      bvalid = 1;
      wait_sig(6, "b_timeout", n);
      step();
      bvalid = 0;
      if (br != 2'b00) m_err = 1;
      chk("err_after_b", err, m_err);
      chk("idle_after_b", busy, 1'b0);
   endtask

   initial begin
      logic [SRCW-1:0] rid_v;
      logic [1:0] rr_v, br_v;
      repeat (3) step();
      chk("reset_state", {claim_valid, claim_id, done_ready, busy, err, spur, arvalid, rready,
                          awvalid, wvalid, bready}, '0);
      rst_n = 1;
      run_txn(5'd5, 2'b00, 2'b00, 0, 0, 0, 0);   // basic
      run_txn(5'd0, 2'b00, 2'b00, 0, 0, 0, 0);   // spurious
      run_txn(5'd17, 2'b00, 2'b00, 0, 3, 0, 0);  // AW late, W early
      run_txn(5'd9, 2'b10, 2'b00, 0, 0, 0, 0);   // SLVERR on claim read
      run_txn(5'd31, 2'b00, 2'b00, 10, 1, 2, 0); // consumer backpressure
      chk("err_sticky", err, 1'b1);
      for (int i = 0; i < 40; i++) begin
         rid_v = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         rr_v = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
         br_v = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
         run_txn(rid_v, rr_v, br_v, $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), 0);
      end
      run_txn(5'd12, 2'b00, 2'b00, 1, 0, 0, 1);  // reset while waiting for done
      run_txn(5'd3, 2'b00, 2'b00, 0, 2, 2, 0);
      repeat (4) step();
      chk("final_queues", {exp_claim_q.size() == 0, exp_aw_q.size() == 0, exp_w_q.size() == 0},
          3'b111);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
